// File: rtl/bpsk_pkg.sv
// Shared BPSK modem definitions: carrier LUT generation, accumulator sizing and tx FSM states.
package bpsk_pkg;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    function automatic int acc_width(input int data_w, input int sps);
        return 2 * data_w + $clog2(sps);
    endfunction

    // Elaboration-time sine via Taylor series so no math library is needed; result rounded half away from zero.
    function automatic int sine_lut(input int k, input int sps, input int amp, input int data_w);
        real pi;
        real x;
        real term;
        real sum;
        real v;
        int  r;
        int  lim;
        pi   = 3.14159265358979323846;
        x    = 2.0 * pi * real'(k) / real'(sps);
        if (x > pi)
            x = x - 2.0 * pi;
        term = x;
        sum  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        v   = real'(amp) * sum;
        r   = (v >= 0.0) ? int'($rtoi(v + 0.5)) : -int'($rtoi(0.5 - v));
        lim = (1 << (data_w - 1)) - 1;
        if (r > lim)
            r = lim;
        if (r < -lim)
            r = -lim;
        return r;
    endfunction

endpackage

// File: rtl/bpsk_modem_if.sv
// Bit-stream and sample-stream signals of the BPSK modem, framing/ADC-DAC side as master.
interface bpsk_modem_if #(
    parameter int DATA_W = 16,
    parameter int SPS    = 8
);
    localparam int ACC_W = bpsk_pkg::acc_width(DATA_W, SPS);

    logic                     tx_bit;
    logic                     tx_valid;
    logic                     tx_ready;
    logic signed [DATA_W-1:0] tx_sample;
    logic                     tx_sample_valid;
    logic                     tx_sof;
    logic signed [DATA_W-1:0] rx_sample;
    logic                     rx_sample_valid;
    logic                     rx_sof;
    logic                     rx_bit;
    logic                     rx_bit_valid;
    logic signed [ACC_W-1:0]  rx_corr;

    modport master (
        output tx_bit, tx_valid, rx_sample, rx_sample_valid, rx_sof,
        input  tx_ready, tx_sample, tx_sample_valid, tx_sof, rx_bit, rx_bit_valid, rx_corr
    );

    modport slave (
        input  tx_bit, tx_valid, rx_sample, rx_sample_valid, rx_sof,
        output tx_ready, tx_sample, tx_sample_valid, tx_sof, rx_bit, rx_bit_valid, rx_corr
    );
endinterface

// File: rtl/bpsk_correlator.sv
// Receive integrate-and-dump: correlates one symbol of samples against the carrier and decides the bit.
module bpsk_correlator
    import bpsk_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  SPS    = 8,
    parameter int  DIFF   = 0,
    localparam int ACC_W  = acc_width(DATA_W, SPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] lut [SPS],
    input  logic signed [DATA_W-1:0] rx_sample,
    input  logic                     rx_sample_valid,
    input  logic                     rx_sof,
    output logic                     rx_bit,
    output logic                     rx_bit_valid,
    output logic signed [ACC_W-1:0]  rx_corr
);
    localparam int PH_W = $clog2(SPS);

    logic                       started;
    logic [PH_W-1:0]            phase;
    logic [PH_W-1:0]            ph_eff;
    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic                       take;
    logic                       dump;
    logic                       d;
    logic                       d_prev;

    // A sof always restarts at phase 0, discarding any partial sum.
    assign take   = rx_sample_valid && (rx_sof || started);
    assign ph_eff = rx_sof ? '0 : phase;
    assign prod   = rx_sample * lut[ph_eff];
    assign d      = !acc[ACC_W-1] && (acc != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started      <= 1'b0;
            phase        <= '0;
            acc          <= '0;
            dump         <= 1'b0;
            d_prev       <= 1'b0;
            rx_bit       <= 1'b0;
            rx_bit_valid <= 1'b0;
            rx_corr      <= '0;
        end else begin
            rx_bit_valid <= 1'b0;
            dump         <= 1'b0;
            if (dump) begin
                rx_corr      <= acc;
                rx_bit       <= (DIFF != 0) ? (d ^ d_prev) : d;
                d_prev       <= d;
                rx_bit_valid <= 1'b1;
            end
            if (take) begin
                started <= 1'b1;
                acc     <= (ph_eff == '0) ? ACC_W'(prod) : acc + ACC_W'(prod);
                phase   <= ph_eff + 1'b1;
                dump    <= (ph_eff == PH_W'(SPS - 1));
            end
        end
    end

endmodule

// File: rtl/bpsk_modem.sv
// BPSK/DBPSK modem top: carrier LUT, transmit FSM with differential encoder, and the receive correlator.
//   state   | meaning
//   S_IDLE  | no symbol in flight, tx_ready high, tx_sample held at 0
//   S_SEND  | emitting carrier samples; tx_ready only on the last phase
module bpsk_modem
    import bpsk_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SPS    = 8,
    parameter int AMP    = 10000,
    parameter int DIFF   = 0
) (
    input logic         clk,
    input logic         rst_n,
    bpsk_modem_if.slave bus
);
    localparam int         PH_W   = $clog2(SPS);
    localparam logic [0:0] S_IDLE = TX_IDLE;
    localparam logic [0:0] S_SEND = TX_SEND;

    logic signed [DATA_W-1:0] lut [SPS];

    for (genvar k = 0; k < SPS; k++) begin : g_lut
        assign lut[k] = DATA_W'(sine_lut(k, SPS, AMP, DATA_W));
    end

    logic [0:0]               tx_state;
    logic [0:0]               tx_state_nxt;
    logic [PH_W-1:0]          tx_phase;
    logic [PH_W-1:0]          tx_phase_nxt;
    logic                     tx_sym;
    logic                     tx_sym_nxt;
    logic                     tx_last;
    logic                     tx_accept;
    logic signed [DATA_W-1:0] lut_tx;
    logic signed [DATA_W-1:0] tx_sample_nxt;

    assign tx_last      = (tx_phase == PH_W'(SPS - 1));
    assign bus.tx_ready = (tx_state == S_IDLE) || tx_last;
    assign tx_accept    = bus.tx_valid && bus.tx_ready;
    assign lut_tx       = lut[tx_phase_nxt];

    // tx_sym doubles as the differential reference, so it survives idle gaps.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_phase_nxt = tx_phase;
        tx_sym_nxt   = tx_sym;
        if (tx_accept) begin
            tx_state_nxt = S_SEND;
            tx_phase_nxt = '0;
            tx_sym_nxt   = (DIFF != 0) ? (bus.tx_bit ^ tx_sym) : bus.tx_bit;
        end else if (tx_state == S_SEND) begin
            if (tx_last) begin
                tx_state_nxt = S_IDLE;
                tx_phase_nxt = '0;
            end else begin
                tx_phase_nxt = tx_phase + 1'b1;
            end
        end
    end

    always_comb begin
        tx_sample_nxt = '0;
        if (tx_state_nxt == S_SEND)
            tx_sample_nxt = tx_sym_nxt ? lut_tx : -lut_tx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state            <= S_IDLE;
            tx_phase            <= '0;
            tx_sym              <= 1'b0;
            bus.tx_sample       <= '0;
            bus.tx_sample_valid <= 1'b0;
            bus.tx_sof          <= 1'b0;
        end else begin
            tx_state            <= tx_state_nxt;
            tx_phase            <= tx_phase_nxt;
            tx_sym              <= tx_sym_nxt;
            bus.tx_sample       <= tx_sample_nxt;
            bus.tx_sample_valid <= (tx_state_nxt == S_SEND);
            bus.tx_sof          <= tx_accept;
        end
    end

    bpsk_correlator #(
        .DATA_W (DATA_W),
        .SPS    (SPS),
        .DIFF   (DIFF)
    ) u_corr (
        .clk             (clk),
        .rst_n           (rst_n),
        .lut             (lut),
        .rx_sample       (bus.rx_sample),
        .rx_sample_valid (bus.rx_sample_valid),
        .rx_sof          (bus.rx_sof),
        .rx_bit          (bus.rx_bit),
        .rx_bit_valid    (bus.rx_bit_valid),
        .rx_corr         (bus.rx_corr)
    );

endmodule
